gf_poly_reducer: RTL and testbench

GF_POLY_REDUCER -- requirements
Module: gf_poly_reducer

---
 rtl/gf_poly_reducer.sv | 116 +++++++++++
 tb/tb_gf_poly_reducer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_poly_reducer.sv
// Reduces a 2W-bit product modulo POLY, either carry-less over GF(2) or as
// unsigned integer division. One reduction step per cycle, MSB shift first.
module gf_poly_reducer #(
  parameter int DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH:0] POLY = 5'b10011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      carry_option,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   product,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH:0]       remainder,
  output logic [DATA_WIDTH-1:0]     quotient
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [2*W-1:0] POLY_EXT = (2*W)'(POLY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg;
  logic [2*W-1:0]  acc_reg;
  logic [2*W-1:0]  acc_next;
  logic [W-1:0]    quot_reg;
  logic [CW-1:0]   cnt_reg;
  logic            mode_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;

  // POLY aligned to every shift position a reduction step can use
  logic [2*W-1:0]  poly_tab [W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_poly_tab
      assign poly_tab[gi] = POLY_EXT << gi;
    end
  endgenerate

  logic [2*W-1:0]  sel_poly;
  logic [2*W-1:0]  shifted;
  logic [2*W-1:0]  diff;
  logic            step_bit;

  always_comb begin
    sel_poly = poly_tab[cnt_reg];
    shifted  = acc_reg >> cnt_reg;
    diff     = acc_reg - sel_poly;
    // Integer mode cannot overflow: acc < POLY<<(s+1) holds before every step
    if (mode_reg) begin
      step_bit = (acc_reg >= sel_poly);
    end else begin
      step_bit = shifted[W];
    end
    acc_next = acc_reg;
    if (step_bit) begin
      acc_next = mode_reg ? diff : (acc_reg ^ sel_poly);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      quot_reg      <= '0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            acc_reg      <= product;
            mode_reg     <= carry_option;
            quot_reg     <= '0;
            cnt_reg      <= CW'(W - 1);
            in_ready_reg <= 1'b0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          acc_reg           <= acc_next;
          quot_reg[cnt_reg] <= step_bit;
          if (cnt_reg == '0) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign remainder = acc_reg[W:0];
  assign quotient  = quot_reg;

endmodule

// File: tb/tb_gf_poly_reducer.sv
// Directed bench for gf_poly_reducer (W=4, POLY=x^4+x+1) with hand-computed
// results, plus an invariant sweep over random products.
module tb_gf_poly_reducer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       carry_option;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] product;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] remainder;
  logic [3:0] quotient;

  int n_vec = 0;
  int n_err = 0;

  gf_poly_reducer #(.DATA_WIDTH(4), .POLY(5'b10011)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .carry_option (carry_option),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .remainder    (remainder),
    .quotient     (quotient)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clmul(input logic [3:0] a, input logic [4:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) if (a[i]) r = r ^ (8'(b) << i);
    return r;
  endfunction

  // Presents a product while IDLE; returns #1 after the accept edge
  task automatic start(input logic [7:0] p, input logic m);
    product = p; carry_option = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [7:0] p, input logic m,
                    input logic [4:0] er, input logic [3:0] eq);
    int lat;
    start(p, m);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_quo"}, quotient, eq);
    $display("op %s product=%02h mode=%0d -> rem=%0d quo=%0d lat=%0d", tag, p, m, remainder, quotient, lat);
    release_result();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    logic [4:0] hold_r;
    logic [3:0] hold_q;
    logic [7:0] p;
    logic m;

    // Reset with in_valid high: nothing may be accepted
    rst_n = 1'b0; in_valid = 1'b1; product = 8'h00; carry_option = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_quo", quotient, 0);
    $display("reset held with in_valid=1: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // First edge with rst_n=1 accepts product 0 (GF), no shortcut
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_accept", in_ready, 0);
    wait_done(lat);
    chk("zero_lat", lat, 4);
    chk("zero_rem", remainder, 0);
    chk("zero_quo", quotient, 0);
    $display("op zero product=00 -> rem=%0d quo=%0d lat=%0d", remainder, quotient, lat);
    release_result();

    op("gf_78", 8'h78, 1'b0, 5'd1, 4'd7);
    op("gf_4b", 8'h4B, 1'b0, 5'd7, 4'd4);
    op("int_195", 8'd195, 1'b1, 5'd5, 4'd10);
    op("gf_ff", 8'hFF, 1'b0, 5'd13, 4'd14);
    op("int_ff", 8'hFF, 1'b1, 5'd8, 4'd13);
    op("int_18", 8'd18, 1'b1, 5'd18, 4'd0);
    op("int_19", 8'd19, 1'b1, 5'd0, 4'd1);

    // Backpressure: hold DONE for 5 cycles with in_valid pulses
    start(8'h78, 1'b0);
    wait_done(lat);
    chk("bp_lat", lat, 4);
    hold_r = remainder; hold_q = quotient;
    chk("bp_rem0", hold_r, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0); product = 8'hAA; carry_option = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_rem", remainder, 5'd1);
      chk("bp_quo", quotient, 4'd7);
      $display("bp cycle %0d: out_valid=%0d in_ready=%0d rem=%0d quo=%0d", k, out_valid, in_ready, remainder, quotient);
    end
    // in_valid stays high across the release edge; it must not be accepted
    in_valid = 1'b1;
    release_result();
    in_valid = 1'b0;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_idle", in_ready, 1);
    $display("bp release: out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // carry_option toggled during BUSY must not disturb the latched mode
    start(8'd195, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      carry_option = ~carry_option;
      @(posedge clk); #1;
      lat++;
    end
    chk("tog_lat", lat, 4);
    chk("tog_rem", remainder, 5);
    chk("tog_quo", quotient, 10);
    $display("op toggle product=195 -> rem=%0d quo=%0d lat=%0d", remainder, quotient, lat);
    release_result();

    // Reset in the second BUSY cycle aborts the operation
    start(8'h78, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_quo", quotient, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    $display("abort: in_ready=%0d out_valid_seen=%0d", in_ready, seen);
    op("post_abort", 8'hFF, 1'b1, 5'd8, 4'd13);

    // Invariant sweep, random products/modes/out_ready delay
    for (int k = 0; k < 24; k++) begin
      p = 8'($urandom_range(0, 255));
      m = 1'($urandom_range(0, 1));
      start(p, m);
      wait_done(lat);
      chk("rnd_lat", lat, 4);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      if (m) begin
        chk("rnd_int_inv", 32'(quotient) * 32'd19 + 32'(remainder), 32'(p));
        chk("rnd_int_lt", 32'(remainder < 5'd19), 1);
      end else begin
        chk("rnd_gf_inv", clmul(quotient, 5'b10011) ^ 8'(remainder), p);
        chk("rnd_gf_msb", remainder[4], 0);
      end
      $display("rnd %0d product=%02h mode=%0d -> rem=%0d quo=%0d", k, p, m, remainder, quotient);
      release_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
